commit_trace_queue: RTL

Collects per-cycle retirement events from the DUT's parallel commit ports and its trap port, and serializes them into a single in-order event stream for the co-simulation checker. Sits between the core's trace outputs and the checker that issues one commit or trap call per event. The DUT cannot be stalled, so the block absorbs bursts in a FIFO and reports any loss through a sticky overflow flag.

---
 rtl/commit_trace_queue_if.sv | 50 +++++
 rtl/commit_trace_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/commit_trace_queue_if.sv
// rtl/commit_trace_queue_if.sv - trace capture and serialized event stream bundle for commit_trace_queue
// out_cycle exists only when CJ_TRACE_TIMESTAMP_EN is defined.
interface commit_trace_queue_if #(
  parameter int COMMITS = 2,
  parameter int XLEN    = 64
);
  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;

  logic                    out_valid;
  logic                    out_ready;
  logic                    out_is_trap;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [XLEN-1:0]         out_cause;
  logic                    overflow;
  logic [15:0]             drop_count;
`ifdef CJ_TRACE_TIMESTAMP_EN
  logic [63:0]             out_cycle;
`endif

  modport master (
    output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
    output trap_valid, trap_cause, out_ready,
`ifdef CJ_TRACE_TIMESTAMP_EN
    input  out_cycle,
`endif
    input  out_valid, out_is_trap, out_pc, out_insn, out_wen, out_waddr,
    input  out_wdata, out_cause, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
    input  trap_valid, trap_cause, out_ready,
`ifdef CJ_TRACE_TIMESTAMP_EN
    output out_cycle,
`endif
    output out_valid, out_is_trap, out_pc, out_insn, out_wen, out_waddr,
    output out_wdata, out_cause, overflow, drop_count
  );
endinterface

// File: rtl/commit_trace_queue.sv
// rtl/commit_trace_queue.sv - serializes per-cycle commit/trap events into one in-order stream
// Optional per-entry cycle stamp on out_cycle when CJ_TRACE_TIMESTAMP_EN is defined.
module commit_trace_queue #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  commit_trace_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GN = COMMITS + 1;

  // A trap's cause shares the wdata field; the consumer reads it through out_cause.
  typedef struct packed {
    logic            is_trap;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          grp [GN];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, space, n_push;
  logic            accept, drop, pop;
  logic            overflow_q;
  logic [15:0]     drop_q;

  always_comb begin
    int pos;
    pos = 0;
    for (int k = 0; k < GN; k++) grp[k] = '0;
    for (int i = 0; i < COMMITS; i++) begin
      if (bus.in_valid[i]) begin
        for (int k = 0; k < GN; k++) begin
          if (pos == k) begin
            grp[k] = '{is_trap: 1'b0,
                       pc:      bus.in_pc[i*XLEN +: XLEN],
                       insn:    bus.in_insn[i*32 +: 32],
                       wen:     bus.in_wen[i],
                       waddr:   bus.in_waddr[i*5 +: 5],
                       wdata:   bus.in_wdata[i*XLEN +: XLEN]};
          end
        end
        pos = pos + 1;
      end
    end
    if (bus.trap_valid) begin
      for (int k = 0; k < GN; k++) begin
        if (pos == k) begin
          grp[k] = '{is_trap: 1'b1, pc: '0, insn: '0, wen: 1'b0, waddr: '0,
                     wdata: bus.trap_cause};
        end
      end
      pos = pos + 1;
    end
    n_push = CW'(pos);
  end

  // Space is judged before this cycle's pop so a group is never split or credited early.
  assign space  = CW'(DEPTH) - count;
  assign accept = (n_push != '0) && (n_push <= space);
  assign drop   = (n_push != '0) && !accept;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + (accept ? n_push : CW'(0)) - CW'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

`ifdef CJ_TRACE_TIMESTAMP_EN
  logic [63:0] cycle_cnt;
  logic [63:0] stamp_mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 64'd1;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < GN; k++) begin
        if (CW'(k) < n_push) stamp_mem[wr_ptr + PW'(k)] <= cycle_cnt;
      end
    end
  end

  assign bus.out_cycle = stamp_mem[rd_ptr];
`endif

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < GN; k++) begin
        if (CW'(k) < n_push) mem[wr_ptr + PW'(k)] <= grp[k];
      end
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.out_valid   = (count != '0);
  assign bus.out_is_trap = head.is_trap;
  assign bus.out_pc      = head.pc;
  assign bus.out_insn    = head.insn;
  assign bus.out_wen     = head.wen;
  assign bus.out_waddr   = head.waddr;
  assign bus.out_wdata   = head.wdata;
  assign bus.out_cause   = head.wdata;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_q;
endmodule
